// File: rtl/serial_full_add.sv
// serial_full_add: bit-serial ripple adder, {Cout,S} = A + B + Cin.
// One full-adder cell processes one bit per clock, LSB first. A carry
// flop links the bits. The operands, carry-in, bit counter and a
// partial-sum shift register are captured when a request is accepted.
// S/Cout (and V) update only on the completion edge, together with a
// one-cycle done pulse.
// Optional feature: define SERIAL_FULL_ADD_OVF_EN to add output V, the
// two's-complement signed overflow of the addition.
module serial_full_add #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
`ifdef SERIAL_FULL_ADD_OVF_EN
    output logic             Cout,
    output logic             V
`else
    output logic             Cout
`endif
);

    // A counter wide enough to index every bit position 0..WIDTH-1.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Registered state.
    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q,  op_a_d;
    logic [WIDTH-1:0] op_b_q,  op_b_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;
`ifdef SERIAL_FULL_ADD_OVF_EN
    logic             ovf_q,   ovf_d;
`endif

    // Full-adder cell outputs for the bit currently at the LSB.
    logic             sum_bit;
    logic             carry_nxt;
    logic             last_bit;
    logic [WIDTH-1:0] acc_nxt;

    // Single full-adder cell operating on the LSBs of the shift registers.
    always_comb begin
        sum_bit   = op_a_q[0] ^ op_b_q[0] ^ carry_q;
        carry_nxt = (op_a_q[0] & op_b_q[0]) | (carry_q & (op_a_q[0] ^ op_b_q[0]));
        acc_nxt   = {sum_bit, acc_q[WIDTH-1:1]};
        last_bit  = (cnt_q == CNT_LAST);
    end

    // Next-state logic: request acceptance, per-bit shifting and completion.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_FULL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // start is only looked at here, so requests arriving while
                // busy are simply dropped rather than queued.
                if (start) begin
                    op_a_d  = A;
                    op_b_d  = B;
                    carry_d = Cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                carry_d = carry_nxt;
                acc_d   = acc_nxt;
                op_a_d  = op_a_q >> 1;
                op_b_d  = op_b_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);

                if (last_bit) begin
                    // Publish the complete sum, including the bit computed
                    // on this very edge; outputs never show partial results.
                    sum_d   = acc_nxt;
                    cout_d  = carry_nxt;
`ifdef SERIAL_FULL_ADD_OVF_EN
                    // Signed overflow: carry into the MSB differs from the
                    // carry out of it.
                    ovf_d   = carry_q ^ carry_nxt;
`endif
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight and wins over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_FULL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_FULL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = sum_q;
    assign Cout = cout_q;
`ifdef SERIAL_FULL_ADD_OVF_EN
    assign V    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_full_add.sv
// tb_serial_full_add: directed bench for serial_full_add (WIDTH=8).
// Expected {V,Cout,S} is pushed to a queue when a request is driven and
// popped when done is observed. Inputs are driven and outputs sampled on
// the falling clock edge.
module tb_serial_full_add;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
`ifdef SERIAL_FULL_ADD_OVF_EN
    logic             v;
`endif

    int errors = 0;
    int checks = 0;

    // Expected results: {v, cout, s}.
    logic [WIDTH+1:0] exp_q[$];
    logic [WIDTH-1:0] prev_s;
    logic             prev_cout;

    serial_full_add #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (a),
        .B    (b),
        .Cin  (cin),
        .busy (busy),
        .done (done),
        .S    (s),
`ifdef SERIAL_FULL_ADD_OVF_EN
        .Cout (cout),
        .V    (v)
`else
        .Cout (cout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model: plain integer addition, overflow from sign bits.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic ci);
        logic [WIDTH:0] sum;
        logic           ovf;
        sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        return {ovf, sum};
    endfunction

    // Wait (bounded) for done; while waiting S/Cout must hold their old values.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (done !== 1'b1 && n < 64) begin
            check({tag, "_s_hold"}, s, prev_s);
            @(negedge clk);
            n++;
        end
        if (n >= 64) check({tag, "_timeout"}, done, 1'b1);
    endtask

    // Pop the scoreboard and compare the published result.
    task automatic check_result(input string tag);
        logic [WIDTH+1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, exp_q.size(), 1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_s"}, s, e[WIDTH-1:0]);
        check({tag, "_cout"}, cout, e[WIDTH]);
`ifdef SERIAL_FULL_ADD_OVF_EN
        check({tag, "_v"}, v, e[WIDTH+1]);
`endif
        check({tag, "_busy_at_done"}, busy, 1'b0);
        prev_s    = e[WIDTH-1:0];
        prev_cout = e[WIDTH];
    endtask

    // One isolated addition with latency and pulse-width checks.
    task automatic run_add(input string tag, input logic [WIDTH-1:0] x,
                           input logic [WIDTH-1:0] y, input logic ci);
        int n;
        a = x; b = y; cin = ci; start = 1'b1;
        exp_q.push_back(model(x, y, ci));
        @(negedge clk);
        start = 1'b0;
        a = ~x; b = ~y; cin = ~ci;  // operands must already be captured
        check({tag, "_busy"}, busy, 1'b1);
        wait_done(tag, n);
        check({tag, "_latency"}, n, WIDTH);
        check_result(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_cout_hold"}, cout, prev_cout);
    endtask

    initial begin
        int n1;
        int n2;
        int dones;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        prev_s = '0; prev_cout = 1'b0;

        // Reset then idle
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_s", s, 8'h00);
        check("rst_cout", cout, 1'b0);
`ifdef SERIAL_FULL_ADD_OVF_EN
        check("rst_v", v, 1'b0);
`endif
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("idle_no_done", dones, 0);

        // Basic, carry chain, wrap and overflow cases
        run_add("basic", 8'h35, 8'h4A, 1'b0);
        run_add("wrap_ff", 8'hFF, 8'h00, 1'b1);
        run_add("wrap_80", 8'h80, 8'h80, 1'b0);
        run_add("ovf_7f", 8'h7F, 8'h01, 1'b0);
        run_add("mixed", 8'hC3, 8'h5A, 1'b1);

        // Back-to-back with start held high, operands changed mid-operation
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        exp_q.push_back(model(8'h10, 8'h20, 1'b0));
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        a = 8'h01; b = 8'h02;
        exp_q.push_back(model(8'h01, 8'h02, 1'b0));
        wait_done("b2b_first", n1);
        check_result("b2b_first");
        @(negedge clk);
        start = 1'b0;
        check("b2b_reaccept_busy", busy, 1'b1);
        wait_done("b2b_second", n2);
        check("b2b_gap", n2 + 1, WIDTH + 1);
        check_result("b2b_second");

        // Extra start pulses while busy produce no extra done
        @(negedge clk);
        a = 8'h0C; b = 8'h03; cin = 1'b0; start = 1'b1;
        exp_q.push_back(model(8'h0C, 8'h03, 1'b0));
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) begin
                dones++;
                check_result("ignored_start");
            end
            if (i == 2 || i == 5) begin
                a = 8'hEE; b = 8'h11; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("ignored_start_dones", dones, 1);

        // Reset mid-operation
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(negedge clk);           // accepted at edge k
        start = 1'b0;
        @(negedge clk);           // after k+1
        @(negedge clk);           // after k+2
        @(negedge clk);           // after k+3
        rst = 1'b1;               // sampled at edge k+4
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_s", s, 8'h00);
        check("midrst_cout", cout, 1'b0);
        prev_s = '0; prev_cout = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("midrst_no_done", dones, 0);
        run_add("after_rst", 8'hAA, 8'h55, 1'b0);

        // rst and start on the same edge: rst wins
        a = 8'h01; b = 8'h01; start = 1'b1; rst = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        check("rst_vs_start_busy", busy, 1'b0);
        prev_s = '0; prev_cout = 1'b0;

        check("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
